// File: rtl/keypad_div_if.sv
// ---------------------------------------------------------------------------
// keypad_div_if
//   Bundles the key-entry handshake and the result/status signals between
//   the keypad scanner, the division controller and the display path.
//
//   Parameter:
//     W          operand/result width in bits
//
//   Signals:
//     key_valid  one-cycle key pulse          (scanner -> controller)
//     key_code   4-bit key code               (scanner -> controller)
//     disp_val   value for the BCD converter  (controller -> display)
//     quot, rem  last quotient / remainder
//     show_rem   display shows the remainder in RESULT
//     busy       division in progress
//     done       one-cycle pulse when quot/rem update
//     div_zero   last division had a zero divisor
//     ovf        sticky digit-rejected flag
//     phase      0 ENTER_A, 1 ENTER_B, 2 DIVIDE, 3 RESULT
//
//   Modports:
//     master     key source / result consumer (scanner side, testbench)
//     slave      the division controller
// ---------------------------------------------------------------------------
interface keypad_div_if #(
    parameter int W = 8
);
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] disp_val;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         show_rem;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         ovf;
    logic [1:0]   phase;

    modport master (
        output key_valid, key_code,
        input  disp_val, quot, rem, show_rem, busy, done, div_zero, ovf, phase
    );

    modport slave (
        input  key_valid, key_code,
        output disp_val, quot, rem, show_rem, busy, done, div_zero, ovf, phase
    );
endinterface

// File: rtl/keypad_div_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_div_ctrl
//   Keypad-driven division controller. Accumulates two decimal operands from
//   single-cycle key pulses, divides A by B with a W-bit restoring divider
//   (one quotient bit per clock), and presents quotient or remainder on the
//   display bus.
//
//   Parameters:
//     W        operand/result width in bits (4..16)
//     DIGITS   maximum decimal digits accepted per operand
//
//   Ports:
//     clk      clock
//     rst      asynchronous, active-low reset
//     bus      keypad_div_if.slave: key_valid/key_code in; disp_val, quot,
//              rem, show_rem, busy, done, div_zero, ovf, phase out
//
//   Key codes: 0-9 digit, 0xA enter, 0xB toggle quotient/remainder,
//              0xC clear, 0xD-0xF ignored.
//
//   Build option:
//     KDIV_CHAIN_EN  when defined, Enter in RESULT loads the quotient as the
//                    next dividend and jumps to divisor entry (chained
//                    division). When undefined, Enter in RESULT is ignored.
// ---------------------------------------------------------------------------
module keypad_div_ctrl #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    keypad_div_if.slave  bus
);

    // Phase encoding is visible on the phase output, so it is fixed here.
    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] DIVIDE  = 2'd2;
    localparam logic [1:0] RESULT  = 2'd3;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_TOGGLE = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    localparam int CW = $clog2(DIGITS + 1);  // digit counter width
    localparam int IW = $clog2(W);           // divider bit-index width

    localparam logic [W-1:0] ALL_ONES = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [W-1:0]  acc;          // operand being typed
    logic [CW-1:0] dig_cnt;      // digits accepted into acc
    logic [W-1:0]  a_reg;        // dividend
    logic [W-1:0]  b_reg;        // divisor
    logic [W-1:0]  r_work;       // partial remainder (always < b_reg)
    logic [W-1:0]  q_work;       // quotient bits shifted in so far
    logic [IW-1:0] bit_idx;      // dividend bit consumed by next iteration
    logic [W-1:0]  quot_r;
    logic [W-1:0]  rem_r;
    logic          show_rem_r;
    logic          done_r;
    logic          div_zero_r;
    logic          ovf_r;

    // ------------------------------------------------------------------
    // Digit accumulation: cand = acc*10 + d, computed 4 bits wider than
    // acc so an out-of-range candidate is detected instead of wrapping.
    // ------------------------------------------------------------------
    logic          is_digit;
    logic [W+3:0]  acc_ext;
    logic [W+3:0]  cand;
    logic          digit_ok;

    assign is_digit = (bus.key_code <= 4'd9);
    assign acc_ext  = {4'b0000, acc};
    assign cand     = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, bus.key_code};
    assign digit_ok = (dig_cnt < CW'(DIGITS)) && (cand <= {4'b0000, ALL_ONES});

    // ------------------------------------------------------------------
    // Restoring-divide iteration. The shifted remainder needs W+1 bits;
    // trial[W] is the borrow, i.e. the sign of the trial subtraction.
    // ------------------------------------------------------------------
    logic [W:0]    trial_in;
    logic [W:0]    trial;
    logic          sub_ok;
    logic [W-1:0]  r_next;
    logic [W-1:0]  q_next;

    assign trial_in = {r_work, a_reg[bit_idx]};
    assign trial    = trial_in - {1'b0, b_reg};
    assign sub_ok   = ~trial[W];
    // On success the difference is < b_reg; on restore trial_in < b_reg.
    // Either way the result fits in W bits.
    assign r_next   = sub_ok ? trial[W-1:0] : trial_in[W-1:0];
    assign q_next   = {q_work[W-2:0], sub_ok};

    // ------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------
    // NOTE: every register here is plain flop state (no memory arrays), so
    // all of it is cleared by the asynchronous reset; outputs follow at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ENTER_A;
            acc        <= '0;
            dig_cnt    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            r_work     <= '0;
            q_work     <= '0;
            bit_idx    <= '0;
            quot_r     <= '0;
            rem_r      <= '0;
            show_rem_r <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the pre-edge values of the registers it tests.
            done_r <= 1'b0;

            if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
                // Clear beats anything else, including a final divide
                // iteration on the same edge; the last result is kept.
                state      <= ENTER_A;
                acc        <= '0;
                dig_cnt    <= '0;
                ovf_r      <= 1'b0;
                show_rem_r <= 1'b0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (bus.key_valid) begin
                            if (is_digit) begin
                                if (digit_ok) begin
                                    acc     <= cand[W-1:0];
                                    dig_cnt <= dig_cnt + CW'(1);
                                end else begin
                                    ovf_r <= 1'b1;
                                end
                            end else if (bus.key_code == KEY_ENTER) begin
                                acc     <= '0;
                                dig_cnt <= '0;
                                if (state == ENTER_A) begin
                                    a_reg <= acc;
                                    state <= ENTER_B;
                                end else begin
                                    b_reg      <= acc;
                                    state      <= DIVIDE;
                                    div_zero_r <= 1'b0;
                                    r_work     <= '0;
                                    q_work     <= '0;
                                    bit_idx    <= IW'(W - 1);
                                end
                            end
                        end
                    end

                    DIVIDE: begin
                        if (b_reg == '0) begin
                            // Zero divisor: finish on the first DIVIDE edge.
                            quot_r     <= ALL_ONES;
                            rem_r      <= a_reg;
                            div_zero_r <= 1'b1;
                            done_r     <= 1'b1;
                            state      <= RESULT;
                        end else begin
                            r_work  <= r_next;
                            q_work  <= q_next;
                            bit_idx <= bit_idx - IW'(1);
                            if (bit_idx == '0) begin
                                quot_r <= q_next;
                                rem_r  <= r_next;
                                done_r <= 1'b1;
                                state  <= RESULT;
                            end
                        end
                    end

                    RESULT: begin
                        if (bus.key_valid) begin
                            if (is_digit) begin
                                // A digit starts a fresh dividend entry.
                                acc        <= W'(bus.key_code);
                                dig_cnt    <= CW'(1);
                                show_rem_r <= 1'b0;
                                ovf_r      <= 1'b0;
                                state      <= ENTER_A;
                            end else if (bus.key_code == KEY_TOGGLE) begin
                                show_rem_r <= ~show_rem_r;
                            end else if (bus.key_code == KEY_ENTER) begin
`ifdef KDIV_CHAIN_EN
                                // Chained division: the quotient (all ones
                                // after a zero divisor) becomes the dividend.
                                a_reg      <= quot_r;
                                acc        <= '0;
                                dig_cnt    <= '0;
                                show_rem_r <= 1'b0;
                                state      <= ENTER_B;
`else
                                // Enter has no effect on a displayed result.
                                state      <= RESULT;
`endif
                            end
                        end
                    end

                    default: state <= ENTER_A;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [W-1:0] disp_mux;

    // NOTE: disp_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        disp_mux = '0;
        case (state)
            ENTER_A, ENTER_B: disp_mux = acc;
            RESULT:           disp_mux = show_rem_r ? rem_r : quot_r;
            default:          disp_mux = '0;
        endcase
    end

    assign bus.disp_val = disp_mux;
    assign bus.quot     = quot_r;
    assign bus.rem      = rem_r;
    assign bus.show_rem = show_rem_r;
    assign bus.busy     = (state == DIVIDE);
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.ovf      = ovf_r;
    assign bus.phase    = state;

endmodule

// File: tb/tb_keypad_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_div_ctrl
//   Self-checking bench for keypad_div_ctrl (W=8, DIGITS=3). A behavioural
//   model tracks the operand being typed and computes results with / and %.
//   Honours KDIV_CHAIN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_keypad_div_ctrl;

    localparam int W      = 8;
    localparam int DIGITS = 3;
    localparam int MAXV   = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    keypad_div_if #(.W(W)) bus ();

    keypad_div_ctrl #(.W(W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_phase, m_acc, m_cnt, m_a, m_b, m_quot, m_rem;
    bit m_show, m_ovf, m_dz;

    function automatic void model_reset();
        m_phase = 0; m_acc = 0; m_cnt = 0; m_a = 0; m_b = 0;
        m_quot = 0; m_rem = 0; m_show = 0; m_ovf = 0; m_dz = 0;
    endfunction

    // Effect of one key outside of division timing.
    function automatic void model_key(input int code);
        if (code == 12) begin
            m_phase = 0; m_acc = 0; m_cnt = 0; m_ovf = 0; m_show = 0;
            return;
        end
        case (m_phase)
            0, 1: begin
                if (code <= 9) begin
                    if (m_cnt < DIGITS && m_acc * 10 + code <= MAXV) begin
                        m_acc = m_acc * 10 + code;
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (code == 10) begin
                    if (m_phase == 0) begin
                        m_a = m_acc; m_phase = 1;
                    end else begin
                        m_b = m_acc; m_phase = 2; m_dz = 0;
                    end
                    m_acc = 0; m_cnt = 0;
                end
            end
            3: begin
                if (code <= 9) begin
                    m_acc = code; m_cnt = 1; m_show = 0; m_ovf = 0; m_phase = 0;
                end else if (code == 11) begin
                    m_show = ~m_show;
                end else if (code == 10) begin
`ifdef KDIV_CHAIN_EN
                    m_a = m_quot; m_acc = 0; m_cnt = 0; m_show = 0; m_phase = 1;
`endif
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int model_disp();
        case (m_phase)
            0, 1:    return m_acc;
            3:       return m_show ? m_rem : m_quot;
            default: return 0;
        endcase
    endfunction

    // One key pulse sampled at the next rising edge; returns at the
    // following falling edge with the model updated.
    task automatic send_key(input int code);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(code);
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(code);
    endtask

    task automatic send_number(input int v);
        int dg[DIGITS];
        int n = 0;
        if (v == 0) begin
            send_key(0);
            return;
        end
        while (v > 0 && n < DIGITS) begin
            dg[n] = v % 10;
            v = v / 10;
            n++;
        end
        for (int i = n - 1; i >= 0; i--) send_key(dg[i]);
    endtask

    // Called right after the enter-B key: waits for done, checks latency,
    // busy, and the result against plain integer division.
    task automatic run_divide(input int exp_lat, input bit inject,
                              input int icode, input string tag);
        int cyc = 0;
        bit busy_ok = 1;
        int exp_q, exp_r;
        exp_q = (m_b == 0) ? MAXV : m_a / m_b;
        exp_r = (m_b == 0) ? m_a  : m_a % m_b;
        while (bus.done !== 1'b1 && cyc < W + 4) begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (inject && cyc == 0) begin
                bus.key_valid = 1'b1;
                bus.key_code  = 4'(icode);
            end
            @(negedge clk);
            bus.key_valid = 1'b0;
            cyc++;
        end
        m_phase = 3; m_quot = exp_q; m_rem = exp_r; m_dz = (m_b == 0);

        checks++;
        if (cyc != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles expected %0d", tag, cyc, exp_lat);
        end
        checks++;
        if (!busy_ok || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: window_ok=%0d busy_at_done=%b expected 1/0", tag, busy_ok, bus.busy);
        end
        checks++;
        if (bus.quot !== W'(exp_q) || bus.rem !== W'(exp_r)) begin
            failures++;
            $display("FAIL %s result: got q=%0d r=%0d expected q=%0d r=%0d (a=%0d b=%0d)",
                     tag, bus.quot, bus.rem, exp_q, exp_r, m_a, m_b);
        end
        checks++;
        if (bus.div_zero !== m_dz || bus.phase !== 2'd3 || bus.disp_val !== W'(model_disp())) begin
            failures++;
            $display("FAIL %s status: got dz=%b phase=%0d disp=%0d expected dz=%b phase=3 disp=%0d",
                     tag, bus.div_zero, bus.phase, bus.disp_val, m_dz, model_disp());
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: got done=%b one cycle later expected 0", tag, bus.done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.disp_val !== '0 || bus.quot !== '0 || bus.rem !== '0 || bus.phase !== 2'd0) begin
            failures++;
            $display("FAIL reset_values: got disp=%0d q=%0d r=%0d phase=%0d expected all 0",
                     bus.disp_val, bus.quot, bus.rem, bus.phase);
        end
        checks++;
        if ({bus.show_rem, bus.busy, bus.done, bus.div_zero, bus.ovf} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.show_rem, bus.busy, bus.done, bus.div_zero, bus.ovf});
        end
    endtask

    task automatic test_basic();
        send_key(1); send_key(0); send_key(0);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.phase !== 2'd0) begin
            failures++;
            $display("FAIL basic_entry_a: got disp=%0d phase=%0d expected disp=%0d phase=0",
                     bus.disp_val, bus.phase, model_disp());
        end
        send_key(10);
        send_key(7);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.phase !== 2'd1) begin
            failures++;
            $display("FAIL basic_entry_b: got disp=%0d phase=%0d expected disp=%0d phase=1",
                     bus.disp_val, bus.phase, model_disp());
        end
        send_key(10);
        run_divide(W, 0, 0, "basic_div");
        send_key(11);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.show_rem !== 1'b1) begin
            failures++;
            $display("FAIL basic_toggle_rem: got disp=%0d show_rem=%b expected disp=%0d show_rem=1",
                     bus.disp_val, bus.show_rem, model_disp());
        end
        send_key(11);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.show_rem !== 1'b0) begin
            failures++;
            $display("FAIL basic_toggle_quot: got disp=%0d show_rem=%b expected disp=%0d show_rem=0",
                     bus.disp_val, bus.show_rem, model_disp());
        end
    endtask

    task automatic test_div_zero();
        // Starts from RESULT: the digit begins a new dividend.
        send_key(5);
        checks++;
        if (bus.phase !== 2'd0 || bus.disp_val !== W'(model_disp())) begin
            failures++;
            $display("FAIL dz_new_entry: got phase=%0d disp=%0d expected phase=0 disp=%0d",
                     bus.phase, bus.disp_val, model_disp());
        end
        send_key(10); send_key(0); send_key(10);
        run_divide(1, 0, 0, "div_zero");
    endtask

    task automatic test_clear_mid_divide();
        int q0, r0;
        bit saw_done = 0;
        q0 = m_quot; r0 = m_rem;
        send_key(9); send_key(10); send_key(2); send_key(10);
        repeat (2) @(negedge clk);
        send_key(12);                       // sampled on iteration 3
        checks++;
        if (bus.phase !== 2'd0 || bus.busy !== 1'b0 || bus.disp_val !== '0) begin
            failures++;
            $display("FAIL clear_mid_state: got phase=%0d busy=%b disp=%0d expected 0/0/0",
                     bus.phase, bus.busy, bus.disp_val);
        end
        for (int i = 0; i < W + 2; i++) begin
            if (bus.done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || bus.quot !== W'(q0) || bus.rem !== W'(r0)) begin
            failures++;
            $display("FAIL clear_mid_keep: got done_seen=%0d q=%0d r=%0d expected 0 q=%0d r=%0d",
                     saw_done, bus.quot, bus.rem, q0, r0);
        end
    endtask

    task automatic test_overflow();
        send_key(12);
        send_key(2); send_key(5); send_key(6);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_value: got disp=%0d ovf=%b expected disp=%0d ovf=1",
                     bus.disp_val, bus.ovf, model_disp());
        end
        send_key(12);
        send_key(1); send_key(2); send_key(3); send_key(4);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_digits: got disp=%0d ovf=%b expected disp=%0d ovf=1",
                     bus.disp_val, bus.ovf, model_disp());
        end
        send_key(12);
        checks++;
        if (bus.disp_val !== '0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got disp=%0d ovf=%b expected 0/0", bus.disp_val, bus.ovf);
        end
        send_key(5); send_key(13); send_key(11); send_key(14); send_key(15);
        checks++;
        if (bus.disp_val !== W'(model_disp()) || bus.phase !== 2'd0 || bus.show_rem !== 1'b0) begin
            failures++;
            $display("FAIL ignored_keys: got disp=%0d phase=%0d show_rem=%b expected disp=%0d phase=0 show_rem=0",
                     bus.disp_val, bus.phase, bus.show_rem, model_disp());
        end
        send_key(12);
    endtask

    task automatic test_key_during_divide();
        send_key(4); send_key(2); send_key(10); send_key(5); send_key(10);
        run_divide(W, 1, 3, "key_in_divide");
    endtask

    task automatic test_result_enter();
        send_key(12);
        send_key(1); send_key(0); send_key(0); send_key(10); send_key(7); send_key(10);
        run_divide(W, 0, 0, "chain_first");
        send_key(10);
`ifdef KDIV_CHAIN_EN
        checks++;
        if (bus.phase !== 2'd1 || bus.disp_val !== '0) begin
            failures++;
            $display("FAIL chain_enter: got phase=%0d disp=%0d expected phase=1 disp=0",
                     bus.phase, bus.disp_val);
        end
        send_key(2); send_key(10);
        run_divide(W, 0, 0, "chain_second");
`else
        checks++;
        if (bus.phase !== 2'd3 || bus.disp_val !== W'(model_disp())) begin
            failures++;
            $display("FAIL result_enter_ignored: got phase=%0d disp=%0d expected phase=3 disp=%0d",
                     bus.phase, bus.disp_val, model_disp());
        end
`endif
    endtask

    task automatic test_random();
        int a, b, t;
        for (int n = 0; n < 25; n++) begin
            a = int'($urandom_range(0, MAXV));
            b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, MAXV));
            send_key(12);
            send_number(a);
            send_key(10);
            send_number(b);
            send_key(10);
            run_divide((b == 0) ? 1 : W, 0, 0, "random_div");
            t = int'($urandom_range(0, 3));
            for (int k = 0; k < t; k++) send_key(11);
            checks++;
            if (bus.disp_val !== W'(model_disp()) || bus.show_rem !== m_show) begin
                failures++;
                $display("FAIL random_disp: got disp=%0d show_rem=%b expected disp=%0d show_rem=%b (a=%0d b=%0d)",
                         bus.disp_val, bus.show_rem, model_disp(), m_show, a, b);
            end
        end
    endtask

    task automatic test_async_reset();
        send_key(12);
        send_key(2); send_key(0); send_key(0); send_key(10); send_key(3); send_key(10);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.disp_val !== '0 || bus.quot !== '0 || bus.rem !== '0 || bus.phase !== 2'd0 ||
            {bus.show_rem, bus.busy, bus.done, bus.div_zero, bus.ovf} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: got disp=%0d q=%0d r=%0d phase=%0d flags=%b expected all 0",
                     bus.disp_val, bus.quot, bus.rem, bus.phase,
                     {bus.show_rem, bus.busy, bus.done, bus.div_zero, bus.ovf});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        send_key(8); send_key(10); send_key(3); send_key(10);
        run_divide(W, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_clear_mid_divide();
        test_overflow();
        test_key_during_divide();
        test_result_enter();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_div_ctrl.md
# keypad_div_ctrl

Parametrised keypad-driven division controller. It sits between the debounced keypad scanner and the BCD/7-segment display path. It accumulates decimal operands from single-cycle key pulses and runs an internal W-bit restoring divider, one quotient bit per cycle. It presents quotient or remainder on a selectable display bus, with divide-by-zero and entry-overflow flags.

## Interface
Parameters:
- W, 8, operand/result width in bits (4..16)
- DIGITS, 3, maximum decimal digits accepted per operand

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse; key_code valid
- key_code  in  4  0-9 digit, 0xA enter, 0xB toggle Q/R, 0xC clear, 0xD-0xF ignored
- disp_val  out  W  value for BCD converter
- quot  out  W  last quotient
- rem  out  W  last remainder
- show_rem  out  1  1 = disp_val shows remainder in RESULT
- busy  out  1  high while in DIVIDE
- done  out  1  one-cycle pulse when result registers update
- div_zero  out  1  last division had B=0
- ovf  out  1  sticky: a digit was rejected since last clear/new entry
- phase  out  2  0 ENTER_A, 1 ENTER_B, 2 DIVIDE, 3 RESULT

## Operation
- Reset state: ENTER_A.
  - acc, A, B, quot, rem, disp_val: 0.
  - show_rem, busy, done, div_zero, ovf: 0.
- Digit d in ENTER_A/ENTER_B: cand = acc*10+d.
  - Accept if digit count < DIGITS and cand ≤ 2^W−1.
  - Otherwise acc is unchanged and ovf is set.
- Enter (0xA):
  - In ENTER_A: A←acc, acc←0, → ENTER_B.
  - In ENTER_B: B←acc, acc←0, → DIVIDE.
- Restoring divide: remainder register W+1 bits; per iteration shift in the next MSB of A, trial-subtract B, set quotient bit on non-negative result, restore otherwise.
- B=0: no iterations; quot←2^W−1, rem←A, div_zero←1, → RESULT.
- RESULT keys:
  - 0xB toggles show_rem.
  - Digit starts a new A entry with that digit (acc←d, show_rem←0, ovf←0, → ENTER_A).
  - Enter behaviour per Configuration.
- Clear (0xC) in any state, including mid-DIVIDE: → ENTER_A, acc←0, ovf←0, show_rem←0. quot/rem/div_zero keep their values. No done pulse.
- Keys other than 0xC during DIVIDE are ignored. 0xB outside RESULT is ignored. 0xD-0xF are ignored everywhere.
- disp_val:
  - ENTER_A/ENTER_B: acc.
  - DIVIDE: 0.
  - RESULT: show_rem ? rem : quot.
- div_zero clears when the next division starts.

## Timing
- Key pulse sampled at edge k; state/acc update visible after edge k.
- Division: enter-B key at edge k.
  - Iterations on edges k+1..k+W.
  - quot/rem/phase=RESULT update at edge k+W.
  - done high for the single cycle after edge k+W.
  - busy high for cycles after edges k..k+W−1.
- B=0: RESULT, quot/rem and done at edge k+1; busy high one cycle.
- Clear and a divide iteration on the same edge: clear wins.
- Asynchronous reset mid-divide returns all outputs to reset values immediately.

## Configuration
- KDIV_CHAIN_EN defined: Enter in RESULT loads A←quot, acc←0, show_rem←0, → ENTER_B (chained division; div_zero case loads 2^W−1).
- Not defined: Enter in RESULT is ignored.

## Test plan
- W=8: keys 1,0,0,A,7,A → done exactly 8 cycles after the final A edge; quot=14, rem=2, disp_val=14. Key B → disp_val=2; key B again → 14.
- Keys 5,A,0,A → done one cycle after the final A edge; div_zero=1, quot=255, rem=5, busy high one cycle.
- Keys 2,5,6 → acc=25, ovf=1. With DIGITS=3, keys 1,2,3,4 → acc=123, ovf=1. Key C → acc=0, ovf=0.
- Keys 9,A,2,A then C at iteration 3 → phase=0, no done, quot/rem unchanged from the previous result.
- With KDIV_CHAIN_EN: 100/7 then A,2,A → quot=7, rem=0. Without the macro, Enter in RESULT leaves phase=3.
- rst low mid-divide → all outputs 0, phase=0. After release, 8 A 3 A → quot=2, rem=2.
